// File: rtl/pose_display_mux_if.sv
// rtl/pose_display_mux_if.sv - channel inputs and display bus of the pose display mux
interface pose_display_mux_if #(
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 24,
  parameter int NUM_DIGITS = 6,
  parameter int SEL_W      = $clog2(NUM_CH)
);
  logic [NUM_CH*CH_W-1:0]   ch_data;
  logic [1:0]               mode;
  logic [SEL_W-1:0]         sel;
  logic                     step;
  logic [NUM_DIGITS*4-1:0]  digits;
  logic [NUM_DIGITS-1:0]    digit_en;
  logic [SEL_W-1:0]         cur_ch;
  logic                     ch_changed;

  modport master (
    output ch_data, mode, sel, step,
    input  digits, digit_en, cur_ch, ch_changed
  );

  modport slave (
    input  ch_data, mode, sel, step,
    output digits, digit_en, cur_ch, ch_changed
  );
endinterface

// File: rtl/pose_display_mux.sv
// rtl/pose_display_mux.sv - channel select (manual/auto/freeze), snapshot and blanked digit bus
module pose_display_mux #(
  parameter int NUM_CH       = 2,
  parameter int CH_W         = 24,
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLANK_LZ     = 1,
  parameter int SEL_W        = $clog2(NUM_CH)
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  pose_display_mux_if.slave   bus
);
  localparam int DW    = NUM_DIGITS * 4;
  localparam int CP    = (CH_W < DW) ? CH_W : DW;
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [SEL_W-1:0]      LAST_CH    = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] RST_EN     = (BLANK_LZ != 0) ? NUM_DIGITS'(1) : {NUM_DIGITS{1'b1}};

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_ALT    = 2'b11
  } mode_t;

  logic [CH_W-1:0]       ch_arr [NUM_CH];
  logic [SEL_W-1:0]      cur_ch, cur_ch_next;
  logic [DW-1:0]         snap, snap_next;
  logic [NUM_DIGITS-1:0] en, en_next;
  logic [CNT_W-1:0]      dwell, dwell_next, dwell_eff;
  logic                  step_q, auto_q, ch_changed_q;
  logic                  step_rise, nz;
  logic [CH_W-1:0]       ch_sel;
  mode_t                 mode;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_arr[k] = bus.ch_data[k*CH_W +: CH_W];
  end

  assign mode      = mode_t'(bus.mode);
  assign step_rise = bus.step & ~step_q;
  assign ch_sel    = ch_arr[cur_ch];

  always_comb begin
    snap_next   = snap;
    cur_ch_next = cur_ch;
    dwell_next  = dwell;
    // A counter left over from a frozen auto session is ignored on re-entry.
    dwell_eff   = auto_q ? dwell : '0;

    case (mode)
      MODE_FREEZE: begin
      end
      MODE_AUTO: begin
        snap_next         = '0;
        snap_next[CP-1:0] = ch_sel[CP-1:0];
        if (step_rise || dwell_eff == DWELL_LAST) begin
          dwell_next  = '0;
          cur_ch_next = (cur_ch >= LAST_CH) ? '0 : cur_ch + 1'b1;
        end else begin
          dwell_next = dwell_eff + 1'b1;
        end
      end
      default: begin
        snap_next         = '0;
        snap_next[CP-1:0] = ch_sel[CP-1:0];
        cur_ch_next       = (bus.sel > LAST_CH) ? LAST_CH : bus.sel;
        dwell_next        = '0;
      end
    endcase
  end

  // Digit k lights when any nibble at or above k is non-zero; digit 0 always lit.
  always_comb begin
    nz      = 1'b0;
    en_next = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz         = nz | (snap_next[4*k +: 4] != 4'h0);
      en_next[k] = nz;
    end
    en_next[0] = 1'b1;
    if (BLANK_LZ == 0) en_next = '1;
    if (mode == MODE_FREEZE) en_next = en;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_ch       <= '0;
      snap         <= '0;
      en           <= RST_EN;
      dwell        <= '0;
      step_q       <= 1'b0;
      auto_q       <= 1'b0;
      ch_changed_q <= 1'b0;
    end else begin
      cur_ch       <= cur_ch_next;
      snap         <= snap_next;
      en           <= en_next;
      dwell        <= dwell_next;
      step_q       <= bus.step;
      auto_q       <= (mode == MODE_AUTO);
      ch_changed_q <= (cur_ch_next != cur_ch);
    end
  end

  assign bus.digits     = snap;
  assign bus.digit_en   = en;
  assign bus.cur_ch     = cur_ch;
  assign bus.ch_changed = ch_changed_q;
endmodule

// File: tb/tb_pose_display_mux.sv
// tb/tb_pose_display_mux.sv - directed bench for pose_display_mux (3 channels, dwell 8)
module tb_pose_display_mux;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 24;
  localparam int ND     = 6;
  localparam int DWELL  = 8;
  localparam int SEL_W  = 2;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   chg_cnt  = 0;

  pose_display_mux_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_DIGITS(ND), .SEL_W(SEL_W)) bus ();

  pose_display_mux #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_DIGITS(ND),
    .DWELL_CYCLES(DWELL), .BLANK_LZ(1), .SEL_W(SEL_W)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (bus.ch_changed === 1'b1) chg_cnt++;
    end
  endtask

  task automatic set_ch(input int k, input logic [23:0] v);
    bus.ch_data[k*CH_W +: CH_W] = v;
  endtask

  task automatic chk_ch(input string name, input logic [1:0] exp);
    checks++;
    if (bus.cur_ch !== exp) begin
      errors++;
      $display("FAIL %s: cur_ch got %0d expected %0d", name, bus.cur_ch, exp);
    end
  endtask

  task automatic test_reset;
    set_ch(0, 24'h111111); set_ch(1, 24'h00A3F0); set_ch(2, 24'hABCDEF);
    bus.mode = 2'b01; bus.sel = 2'd0; bus.step = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.digits !== 24'h0) begin errors++; $display("FAIL reset_digits: got %h expected 000000", bus.digits); end
    checks++;
    if (bus.digit_en !== 6'b000001) begin errors++; $display("FAIL reset_en: got %b expected 000001", bus.digit_en); end
    chk_ch("reset_cur_ch", 2'd0);
    bus.mode = 2'b00; bus.sel = 2'd1;
    tick(2);
    reset_n = 1'b1;
    chg_cnt = 0;
    tick(1);
    chk_ch("release_cur_ch", 2'd1);
    tick(1);
    checks++;
    if (bus.digits !== 24'h00A3F0) begin errors++; $display("FAIL release_digits: got %h expected 00a3f0", bus.digits); end
    checks++;
    if (bus.digit_en !== 6'b001111) begin errors++; $display("FAIL release_en: got %b expected 001111", bus.digit_en); end
    tick(3);
    checks++;
    if (chg_cnt !== 1) begin errors++; $display("FAIL release_pulse: got %0d expected 1", chg_cnt); end
  endtask

  task automatic test_manual_clamp;
    chg_cnt = 0;
    bus.sel = 2'd3;
    tick(1);
    chk_ch("clamp_cur_ch", 2'd2);
    tick(1);
    checks++;
    if (bus.digits !== 24'hABCDEF) begin errors++; $display("FAIL clamp_digits: got %h expected abcdef", bus.digits); end
    bus.sel = 2'd2;
    tick(3);
    checks++;
    if (chg_cnt !== 1) begin errors++; $display("FAIL same_sel_pulse: got %0d expected 1", chg_cnt); end
  endtask

  task automatic test_auto_wrap;
    chg_cnt  = 0;
    bus.mode = 2'b01;
    tick(7);
    chk_ch("auto_7", 2'd2);
    tick(1);
    chk_ch("auto_8", 2'd0);
    tick(8);
    chk_ch("auto_16", 2'd1);
    tick(8);
    chk_ch("auto_24", 2'd2);
    tick(8);
    chk_ch("auto_32", 2'd0);
    checks++;
    if (chg_cnt !== 4) begin errors++; $display("FAIL auto_pulses: got %0d expected 4", chg_cnt); end
  endtask

  task automatic test_step;
    tick(3);
    bus.step = 1'b1;
    tick(1);
    chk_ch("step_mid", 2'd1);
    bus.step = 1'b0;
    tick(7);
    chk_ch("step_restart_7", 2'd1);
    tick(1);
    chk_ch("step_restart_8", 2'd2);
    tick(7);
    chg_cnt  = 0;
    bus.step = 1'b1;
    tick(1);
    chk_ch("step_collide", 2'd0);
    tick(20);
    chk_ch("step_held", 2'd2);
    checks++;
    if (chg_cnt !== 3) begin errors++; $display("FAIL step_held_pulses: got %0d expected 3", chg_cnt); end
    bus.step = 1'b0;
  endtask

  task automatic test_freeze;
    bus.mode = 2'b00; bus.sel = 2'd0;
    set_ch(0, 24'h123456);
    tick(2);
    bus.mode = 2'b01;
    tick(3);
    bus.mode = 2'b10; bus.sel = 2'd2;
    set_ch(0, 24'hFFFFFF); set_ch(1, 24'hFFFFFF); set_ch(2, 24'hFFFFFF);
    tick(10);
    checks++;
    if (bus.digits !== 24'h123456) begin errors++; $display("FAIL freeze_digits: got %h expected 123456", bus.digits); end
    checks++;
    if (bus.digit_en !== 6'b111111) begin errors++; $display("FAIL freeze_en: got %b expected 111111", bus.digit_en); end
    chk_ch("freeze_cur_ch", 2'd0);
    bus.mode = 2'b00; bus.sel = 2'd0;
    tick(1);
    checks++;
    if (bus.digits !== 24'hFFFFFF) begin errors++; $display("FAIL unfreeze_digits: got %h expected ffffff", bus.digits); end
    bus.mode = 2'b01;
    tick(3);
    bus.mode = 2'b10;
    tick(4);
    bus.mode = 2'b01;
    tick(7);
    chk_ch("refreeze_7", 2'd0);
    tick(1);
    chk_ch("refreeze_8", 2'd1);
  endtask

  task automatic test_blanking;
    bus.mode = 2'b00; bus.sel = 2'd1;
    set_ch(1, 24'h000000);
    tick(2);
    checks++;
    if (bus.digit_en !== 6'b000001) begin errors++; $display("FAIL blank_zero: got %b expected 000001", bus.digit_en); end
    set_ch(1, 24'h100000);
    tick(1);
    checks++;
    if (bus.digit_en !== 6'b111111) begin errors++; $display("FAIL blank_top: got %b expected 111111", bus.digit_en); end
    set_ch(1, 24'h000010);
    tick(1);
    checks++;
    if (bus.digit_en !== 6'b000011) begin errors++; $display("FAIL blank_low: got %b expected 000011", bus.digit_en); end
    checks++;
    if (bus.digits !== 24'h000010) begin errors++; $display("FAIL blank_digits: got %h expected 000010", bus.digits); end
  endtask

  initial begin
    bus.ch_data = '0;
    bus.mode    = 2'b00;
    bus.sel     = '0;
    bus.step    = 1'b0;
    test_reset();
    test_manual_clamp();
    test_auto_wrap();
    test_step();
    test_freeze();
    test_blanking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pose_display_mux.md
Name: pose_display_mux

Overview:
- Parametrised successor to the single-bit pose/orientation display select.
- Selects one of NUM_CH packed data channels (position, orientation, velocity, ...), registers a snapshot and drives a NUM_DIGITS-nibble bus with per-digit enables to the seven-segment decoders.
- Supports three modes: manual select, timed auto-cycling with a step button, and freeze (display hold).
- Optional leading-zero blanking.
- Sits between Pose_Tracker outputs and the Hexadecimal_To_Seven_Segment instances at top level.

Parameters:
- NUM_CH, 2, number of input channels (>=2).
- CH_W, 24, bits per channel.
- NUM_DIGITS, 6, displayed nibbles.
- DWELL_CYCLES, 50000000, clocks per channel in auto mode (>=2).
- BLANK_LZ, 1, 1 = blank leading zero digits.
- SEL_W, $clog2(NUM_CH), select width.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ch_data  in  NUM_CH*CH_W  packed channels; channel k at [k*CH_W +: CH_W].
- mode  in  2  00 manual, 01 auto, 10 freeze, 11 treated as manual.
- sel  in  SEL_W  manual channel select.
- step  in  1  synchronous level from button; rising edge advances channel in auto mode.
- digits  out  NUM_DIGITS*4  digit k = nibble [4k+3:4k] of snapshot.
- digit_en  out  NUM_DIGITS  1 = digit lit.
- cur_ch  out  SEL_W  channel currently displayed.
- ch_changed  out  1  one-cycle pulse when cur_ch changes.

Behaviour:
- Reset (async assert, sync release via CLOCK_50): cur_ch=0, snapshot=0, digits=0, dwell counter=0, step edge register=0, ch_changed=0.
  - digit_en = 1 (bit0 only) if BLANK_LZ, else all ones.
- Width rule: selected channel zero-extended or truncated (LSBs kept) to NUM_DIGITS*4 bits.
- Snapshot: registered every cycle from channel cur_ch unless mode=freeze.
  - Latency ch_data -> digits: 1 cycle.
  - cur_ch change -> digits of the new channel: 1 further cycle; no mixed-channel frame.
- digit_en is registered in the same cycle as digits, computed from the snapshot's next value.
  - BLANK_LZ=1: digit k lit iff some nibble j>=k is non-zero, or k==0. Digit 0 is always lit.
- Manual (mode 00/11):
  - cur_ch <= sel.
  - sel >= NUM_CH clamps to NUM_CH-1.
  - Dwell counter held at 0; step ignored.
- Auto (01):
  - Dwell counter increments each cycle. At DWELL_CYCLES-1: counter -> 0, cur_ch -> cur_ch+1, wrapping NUM_CH-1 -> 0.
  - Step rising edge (step & ~step_q): immediate advance, counter -> 0.
  - Step edge and dwell terminal in the same cycle: single advance only.
  - Entering auto: counter starts from 0 and cur_ch continues from its current value.
- Freeze (10):
  - cur_ch, snapshot, digits, digit_en and dwell counter all held.
  - Step ignored.
  - On leaving freeze, the snapshot resumes updating next cycle.
  - Freeze -> auto restarts the counter at 0.
- ch_changed: high for exactly one cycle in the cycle after cur_ch takes a different value. Not asserted when sel is rewritten to the same value.
- step_q edge register updates in all modes, so a button held across a mode change into auto does not produce a step.
- Reset mid-dwell or mid-freeze: immediate return to reset values; mode inputs are re-evaluated after release.

Test Plan (NUM_CH=3, CH_W=24, NUM_DIGITS=6, DWELL_CYCLES=8, BLANK_LZ=1):
- Reset: assert reset_n=0 mid-run -> same cycle digits=0, digit_en=6'b000001, cur_ch=0; release with mode=00, sel=1, ch1=24'h00A3F0 -> 2 cycles later digits=24'h00A3F0, digit_en=6'b001111, ch_changed pulsed once.
- Manual clamp: sel=3 -> cur_ch=2, digits=ch2; sel=2 rewritten -> no ch_changed.
- Auto wrap: mode=01 from cur_ch=2 -> cur_ch 0 after 8 cycles, 1 after 16, 2 after 24, 0 after 32; ch_changed pulses every 8 cycles.
- Step collision: step rising at counter=3 -> advance, next advance 8 cycles later; step rising on counter=7 -> exactly one advance; step held high for 20 cycles -> one step advance only.
- Freeze: mode=10 with digits=24'h123456, then change all ch_data to 24'hFFFFFF -> digits stays 24'h123456, cur_ch fixed, counter held; mode=00 -> next cycle digits=24'hFFFFFF.
- Blanking: snapshot 24'h000000 -> digit_en=6'b000001; 24'h100000 -> 6'b111111; 24'h000010 -> 6'b000011.
